// File: rtl/lstm_fx_pkg.sv
// Shared Q6.11 fixed-point constants, the sweep FSM state type and the
// piecewise-linear sigmoid core used by the activation units.
package lstm_fx_pkg;

   localparam int unsigned WIDTH  = 18;       // Q6.11 signed word width
   localparam int unsigned FRAC   = 11;       // fractional bits, scale 2048
   localparam int          Q_MAX  = 131071;
   localparam int          Q_MIN  = -131072;
   localparam int          ONE_Q  = 2048;
   localparam int          HALF_Q = 1024;

   // Offsets of the middle and outer sigmoid segments (0.625, 0.84375)
   localparam int          SEG2_OFS = 1280;
   localparam int          SEG3_OFS = 1728;

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} sweep_state_e;

   // Sigmoid of a non-negative magnitude in Q6.11. The curve is concave for
   // x >= 0, so taking the minimum of the segments keeps it continuous and
   // monotonic (no step at the segment boundaries).
   function automatic int plan_sig(input logic [WIDTH+1:0] ax);
      int a;
      int m;
      a = int'(ax);
      m = ONE_Q;
      if ((a >>> 2) + HALF_Q < m) m = (a >>> 2) + HALF_Q;
      if ((a >>> 3) + SEG2_OFS < m) m = (a >>> 3) + SEG2_OFS;
      if ((a >>> 5) + SEG3_OFS < m) m = (a >>> 5) + SEG3_OFS;
      return m;
   endfunction

endpackage

// File: rtl/act_sweep_gen_if.sv
// Valid/ready stream carrying (x, tanh, sigmoid) triples.
//   master: drives out_valid, out_x, out_tanh, out_sig, out_last; reads out_ready
//   slave : the consumer side
interface act_sweep_gen_if;
   import lstm_fx_pkg::*;

   logic                    out_valid;
   logic                    out_ready;
   logic                    out_last;
   logic signed [WIDTH-1:0] out_x;
   logic signed [WIDTH-1:0] out_tanh;
   logic signed [WIDTH-1:0] out_sig;

   modport master (output out_valid, out_x, out_tanh, out_sig, out_last, input out_ready);
   modport slave  (input out_valid, out_x, out_tanh, out_sig, out_last, output out_ready);

endinterface

// File: rtl/sat_add_q6_11.sv
// Combinational signed saturating add for Q6.11 words.
//   a, b : signed addends
//   y    : a + b clamped to [Q_MIN, Q_MAX]
module sat_add_q6_11
   import lstm_fx_pkg::*;
(
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   output logic signed [WIDTH-1:0] y
);

   logic signed [WIDTH:0] sum;

   always_comb begin
      sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
      if (sum > Q_MAX)      y = WIDTH'(Q_MAX);
      else if (sum < Q_MIN) y = WIDTH'(Q_MIN);
      else                  y = sum[WIDTH-1:0];
   end

endmodule

// File: rtl/sigmoid_q6_11.sv
// Piecewise-linear sigmoid, Q6.11 in and out.
//   x : signed argument
//   y : sigmoid(x) in [0, 2048]
module sigmoid_q6_11
   import lstm_fx_pkg::*;
(
   input  logic signed [WIDTH-1:0] x,
   output logic signed [WIDTH-1:0] y
);

   logic [WIDTH+1:0] ax;
   int               p;

   always_comb begin
      ax = x[WIDTH-1] ? (~{2'b11, x} + 1'b1) : {2'b00, x};
      p  = plan_sig(ax);
      // sigmoid(-x) = 1 - sigmoid(x)
      y  = x[WIDTH-1] ? WIDTH'(ONE_Q - p) : WIDTH'(p);
   end

endmodule

// File: rtl/tanh_q6_11.sv
// Piecewise-linear tanh, Q6.11 in and out, via tanh(x) = 2*sigmoid(2x) - 1.
//   x : signed argument
//   y : tanh(x) in [-2048, 2048]
module tanh_q6_11
   import lstm_fx_pkg::*;
(
   input  logic signed [WIDTH-1:0] x,
   output logic signed [WIDTH-1:0] y
);

   logic [WIDTH+1:0] ax2;
   int               p;

   always_comb begin
      ax2 = x[WIDTH-1] ? ((~{2'b11, x} + 1'b1) << 1) : ({2'b00, x} << 1);
      p   = plan_sig(ax2);
      y   = x[WIDTH-1] ? WIDTH'(ONE_Q - 2 * p) : WIDTH'(2 * p - ONE_Q);
   end

endmodule

// File: rtl/act_sweep_gen.sv
// Activation sweep generator: steps x from x_start by x_step (saturating) for
// x_count samples and streams (x, tanh(x), sigmoid(x)) triples.
//   clk, rst_n            : clock, async active-low reset
//   start                 : begin a sweep (sampled in idle only)
//   x_start/x_step/x_count: sweep configuration, latched on accepted start
//   busy, done            : sweep in progress / one-cycle end pulse
//   os                    : triple stream (master side)
//   mono_err              : only with MONO_CHECK_EN; sticky flag set when a
//                           loaded tanh/sigmoid moves against the sweep direction
module act_sweep_gen
   import lstm_fx_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic signed [WIDTH-1:0] x_start,
   input  logic signed [WIDTH-1:0] x_step,
   input  logic [CNT_W-1:0]        x_count,
   output logic                    busy,
   output logic                    done,
`ifdef MONO_CHECK_EN
   output logic                    mono_err,
`endif
   act_sweep_gen_if.master         os
);

   sweep_state_e            state_q;
   logic signed [WIDTH-1:0] x_q;
   logic signed [WIDTH-1:0] step_q;
   logic [CNT_W-1:0]        rem_q;
   logic signed [WIDTH-1:0] x_nxt;
   logic signed [WIDTH-1:0] tanh_x;
   logic signed [WIDTH-1:0] sig_x;
   logic                    load;

   sat_add_q6_11 u_sat_add (.a(x_q), .b(step_q), .y(x_nxt));
   tanh_q6_11    u_tanh    (.x(x_q), .y(tanh_x));
   sigmoid_q6_11 u_sig     (.x(x_q), .y(sig_x));

   // Output slot is free when empty or being drained this cycle
   assign load = (state_q == StRun) && (!os.out_valid || os.out_ready);

`ifdef MONO_CHECK_EN
   logic mono_bad;
   always_comb begin
      if (step_q[WIDTH-1]) mono_bad = (tanh_x > os.out_tanh) || (sig_x > os.out_sig);
      else                 mono_bad = (tanh_x < os.out_tanh) || (sig_x < os.out_sig);
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         x_q          <= '0;
         step_q       <= '0;
         rem_q        <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         os.out_valid <= 1'b0;
         os.out_last  <= 1'b0;
         os.out_x     <= '0;
         os.out_tanh  <= '0;
         os.out_sig   <= '0;
`ifdef MONO_CHECK_EN
         mono_err     <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
`ifdef MONO_CHECK_EN
                  mono_err <= 1'b0;
`endif
                  if (x_count != '0) begin
                     x_q     <= x_start;
                     step_q  <= x_step;
                     rem_q   <= x_count;
                     busy    <= 1'b1;
                     state_q <= StRun;
                  end else begin
                     done    <= 1'b1;
                     state_q <= StDone;
                  end
               end
            end
            StRun: begin
               if (load) begin
`ifdef MONO_CHECK_EN
                  // out_valid here means a previous triple of this sweep exists
                  if (os.out_valid && mono_bad) mono_err <= 1'b1;
`endif
                  os.out_x     <= x_q;
                  os.out_tanh  <= tanh_x;
                  os.out_sig   <= sig_x;
                  os.out_valid <= 1'b1;
                  os.out_last  <= (rem_q == CNT_W'(1));
                  x_q          <= x_nxt;
                  rem_q        <= rem_q - CNT_W'(1);
                  if (rem_q == CNT_W'(1)) state_q <= StDrain;
               end
            end
            StDrain: begin
               if (os.out_ready) begin
                  os.out_valid <= 1'b0;
                  os.out_last  <= 1'b0;
                  busy         <= 1'b0;
                  done         <= 1'b1;
                  state_q      <= StDone;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_act_sweep_gen.sv
// Self-checking bench for act_sweep_gen. Expected x values come from a
// saturating sweep model; tanh/sigmoid are checked against real-valued
// references within a tolerance, with exact literals at x = 0.
// Build with MONO_CHECK_EN defined to also exercise mono_err.
module tb_act_sweep_gen;

   localparam int TOL = 100;

   logic               clk;
   logic               rst_n;
   logic               start;
   logic signed [17:0] x_start;
   logic signed [17:0] x_step;
   logic [15:0]        x_count;
   logic               busy;
   logic               done;
`ifdef MONO_CHECK_EN
   logic               mono_err;
`endif

   act_sweep_gen_if os ();

   act_sweep_gen dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .x_start  (x_start),
      .x_step   (x_step),
      .x_count  (x_count),
      .busy     (busy),
      .done     (done),
`ifdef MONO_CHECK_EN
      .mono_err (mono_err),
`endif
      .os       (os)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   int exp_x[$];
   int got_x[$];
   int got_t[$];
   int got_s[$];

   bit valid_seen;
   bit expect_done;
   bit done_low;
   bit stall_q;
   int hold_x, hold_t, hold_s, hold_l;

   task automatic check(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
      end
   endtask

   task automatic check_tol(input string name, input int act, input int exp_v, input int tol);
      int d;
      checks++;
      d = act - exp_v;
      if (d < 0) d = -d;
      if (d > tol) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp_v, tol);
      end
   endtask

   function automatic int sat(input int v);
      if (v > 131071) return 131071;
      if (v < -131072) return -131072;
      return v;
   endfunction

   function automatic int ref_tanh(input int x);
      real r;
      r = $tanh(real'(x) / 2048.0) * 2048.0;
      return int'(r);
   endfunction

   function automatic int ref_sig(input int x);
      real r;
      r = 2048.0 / (1.0 + $exp(-real'(x) / 2048.0));
      return int'(r);
   endfunction

   // Out-of-range reads return a sentinel so a short beat list still fails
   function automatic int pick(input int q[$], input int i);
      if (i < q.size()) return q[i];
      return 999999;
   endfunction

   // Compare process: outputs are sampled on the falling edge
   always @(negedge clk) begin
      int ex;
      if (!rst_n) begin
         stall_q     = 1'b0;
         expect_done = 1'b0;
         done_low    = 1'b0;
      end else begin
         if (os.out_valid) valid_seen = 1'b1;
         if (expect_done) begin
            check("done_after_last", done, 1);
            check("busy_low_at_done", busy, 0);
            expect_done = 1'b0;
            done_low    = 1'b1;
         end else if (done_low) begin
            check("done_one_cycle", done, 0);
            done_low = 1'b0;
         end
         if (stall_q && os.out_valid)
            check("stall_hold", int'(os.out_x == hold_x && os.out_tanh == hold_t &&
                                     os.out_sig == hold_s && os.out_last == hold_l), 1);
         stall_q = os.out_valid && !os.out_ready;
         hold_x  = os.out_x;
         hold_t  = os.out_tanh;
         hold_s  = os.out_sig;
         hold_l  = os.out_last;
         if (os.out_valid && os.out_ready) begin
            check("busy_during_beat", busy, 1);
            check("beat_expected", int'(exp_x.size() > 0), 1);
            if (exp_x.size() > 0) begin
               ex = exp_x.pop_front();
               check("beat_x", os.out_x, ex);
               check_tol("beat_tanh", os.out_tanh, ref_tanh(ex), TOL);
               check_tol("beat_sig", os.out_sig, ref_sig(ex), TOL);
               check("beat_last", os.out_last, int'(exp_x.size() == 0));
               if (exp_x.size() == 0) expect_done = 1'b1;
            end
            got_x.push_back(int'(os.out_x));
            got_t.push_back(int'(os.out_tanh));
            got_s.push_back(int'(os.out_sig));
         end
      end
   end

   task automatic kick(input int xs, input int st, input int cnt);
      int v;
      got_x.delete();
      got_t.delete();
      got_s.delete();
      valid_seen = 1'b0;
      v = xs;
      for (int i = 0; i < cnt; i++) begin
         exp_x.push_back(v);
         v = sat(v + st);
      end
      @(posedge clk); #1;
      x_start = 18'(xs);
      x_step  = 18'(st);
      x_count = 16'(cnt);
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_start", busy, int'(cnt != 0));
   endtask

   task automatic run_sweep(input int xs, input int st, input int cnt, input bit toggle,
                            input bit poke);
      int guard;
      bit seen_done;
      os.out_ready = 1'b1;
      kick(xs, st, cnt);
      seen_done = done;
      guard = 0;
      while (!seen_done && guard < cnt * 3 + 20) begin
         if (toggle) os.out_ready = ~os.out_ready;
         start = poke && (guard == 5);
         if (poke && guard == 5) begin
            x_start = 18'sd777;
            x_count = 16'd3;
         end
         @(posedge clk); #1;
         guard++;
         if (done) seen_done = 1'b1;
      end
      start = 1'b0;
      check("done_seen", int'(seen_done), 1);
      check("queue_drained", exp_x.size(), 0);
      check("beat_count", got_x.size(), cnt);
      check("busy_low_after", busy, 0);
      os.out_ready = 1'b1;
      @(posedge clk); #1;
      check("done_cleared", done, 0);
      exp_x.delete();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, os.out_valid, 0);
      check({tag, "_last"}, os.out_last, 0);
      check({tag, "_x"}, os.out_x, 0);
      check({tag, "_tanh"}, os.out_tanh, 0);
      check({tag, "_sig"}, os.out_sig, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
   endtask

   initial begin
      int guard;
      rst_n = 1'b0;
      start = 1'b0;
      x_start = '0;
      x_step = '0;
      x_count = '0;
      os.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;
`ifdef MONO_CHECK_EN
      check("reset_mono_err", mono_err, 0);
`endif

      // Nominal sweep, always ready
      run_sweep(-16384, 2048, 17, 1'b0, 1'b0);
      check("nom_first_x", pick(got_x, 0), -16384);
      check("nom_last_x", pick(got_x, 16), 16384);
      check("nom_zero_x", pick(got_x, 8), 0);
      check("nom_zero_tanh", pick(got_t, 8), 0);
      check("nom_zero_sig", pick(got_s, 8), 1024);

      // Backpressure: ready toggles every cycle
      run_sweep(-16384, 2048, 17, 1'b1, 1'b0);
      check("bp_zero_sig", pick(got_s, 8), 1024);

      // Start pulse while running is ignored
      run_sweep(-16384, 2048, 17, 1'b0, 1'b1);

      // Saturation at both ends
      run_sweep(131000, 100, 3, 1'b0, 1'b0);
      check("satp_x0", pick(got_x, 0), 131000);
      check("satp_x1", pick(got_x, 1), 131071);
      check("satp_x2", pick(got_x, 2), 131071);
      run_sweep(-131000, -2048, 2, 1'b0, 1'b0);
      check("satn_x0", pick(got_x, 0), -131000);
      check("satn_x1", pick(got_x, 1), -131072);

      // Zero count: done pulse, no beats
      run_sweep(5000, 10, 0, 1'b0, 1'b0);
      check("zero_no_valid", int'(valid_seen), 0);

      // Reset while beat 5 of 17 is presented
      kick(-16384, 2048, 17);
      guard = 0;
      while (got_x.size() < 4 && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      check("reach_beat5", int'(got_x.size() >= 4), 1);
      check("beat5_valid", os.out_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      exp_x.delete();
      #10;
      rst_n = 1'b1;
      run_sweep(-4096, 1024, 9, 1'b0, 1'b0);
      check("restart_first_x", pick(got_x, 0), -4096);
      check("restart_zero_sig", pick(got_s, 4), 1024);

`ifdef MONO_CHECK_EN
      run_sweep(-2048, 1, 4096, 1'b0, 1'b0);
      check("mono_up", mono_err, 0);
      run_sweep(2048, -1, 4096, 1'b0, 1'b0);
      check("mono_down", mono_err, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/act_sweep_gen.md
Name: act_sweep_gen

Overview:
- On-chip stimulus source for the Q6.11 activation units (tanh_q6_11, sigmoid_q6_11).
- Sweeps x from a programmed start value by a signed step for a programmed number of samples.
- Drives both activation units and streams (x, tanh, sigmoid) triples out over a valid/ready interface, so the activation results can be produced and consumed in hardware instead of by file-driven vectors.
- Sits beside the LSTM gate datapath as a bring-up and characterisation engine.

Parameters:
- WIDTH, 18, Q6.11 signed word width.
- FRAC, 11, fractional bits (scale 2048).
- CNT_W, 16, width of sample counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin sweep; sampled only in IDLE
- x_start  in  WIDTH  signed first x (Q6.11)
- x_step  in  WIDTH  signed increment per sample (Q6.11)
- x_count  in  CNT_W  number of samples to emit
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at sweep end
- out_valid  out  1  output triple valid
- out_ready  in  1  consumer accepts triple
- out_x  out  WIDTH  signed x of current triple
- out_tanh  out  WIDTH  signed tanh(x), Q6.11
- out_sig  out  WIDTH  signed sigmoid(x), Q6.11
- out_last  out  1  high with final triple

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, out_valid, out_last = 0; out_x, out_tanh, out_sig = 0; internal x and remaining counters = 0. Takes effect immediately, including mid-sweep; any in-flight triple is discarded.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE, start=1 and x_count≠0: latch x_start, x_step and x_count; go to RUN; busy=1 from the next cycle.
- IDLE, start=1 and x_count=0: go to DONE; no beats are emitted.
- start outside IDLE is ignored, and config inputs are ignored outside IDLE.
- RUN, load condition: the output slot is free (out_valid=0, or out_valid=1 and out_ready=1). When it holds:
  - register x into out_x, with tanh/sigmoid of that x (combinational from the instantiated units) into out_tanh/out_sig;
  - set out_valid=1;
  - set out_last=1 if remaining==1;
  - x ← sat(x + x_step); remaining ← remaining−1.
  - When the last sample is loaded, go to DRAIN.
- Latency and throughput: start accepted at edge E0; the first triple is valid after E1; one triple per cycle while out_ready=1.
- Stall (out_valid=1, out_ready=0): out_x, out_tanh, out_sig and out_last hold stable; x and remaining do not advance.
- DRAIN: on handshake of the last triple, out_valid→0 and out_last→0; go to DONE.
- DONE: done=1 for exactly one cycle, busy→0; return to IDLE. start in the same cycle as done is ignored.
- Saturation: the sum is computed in WIDTH+1 bits and clamped to [−131072, 131071]; the sweep continues at the clamp value, repeating it.
- No internal overflow wrap-around is permitted.

Optional Feature:
- Macro: MONO_CHECK_EN.
- When defined:
  - adds output port mono_err (1 bit), sticky and cleared on reset or on accepted start;
  - mono_err sets if, between consecutive loaded triples, out_tanh or out_sig moves against the sweep direction: decreases when x_step≥0, or increases when x_step<0.
  - Equal values are legal.
- When undefined: no port and no compare logic; behaviour is otherwise identical.

Decomposition:
- Package lstm_fx_pkg: WIDTH, FRAC, Q_MAX=131071, Q_MIN=−131072, ONE_Q=2048, HALF_Q=1024, and the FSM state typedef.
- One natural sub-module: sat_add_q6_11 (combinational signed saturating add).
- Activation units are instantiated unchanged.

Test Plan:
- Nominal sweep: x_start=−16384, x_step=2048, x_count=17, out_ready=1 → 17 beats with x=−16384…16384. At x=0: tanh=0, sig=1024. out_last only on beat 17; done pulse one cycle after the final handshake.
- Backpressure: same sweep with out_ready toggling 1,0,1,0… → exactly 17 unique beats, in order, none duplicated or dropped; outputs stable during every stall cycle.
- Saturation: x_start=131000, x_step=100, x_count=3 → x sequence 131000, 131071, 131071.
- Negative saturation: x_start=−131000, x_step=−2048, x_count=2 → x sequence −131000, −131072.
- Zero count and busy start: x_count=0 → done pulse, out_valid never rises. A second start during RUN → ignored, beat count unchanged.
- Reset mid-run: rst_n low during beat 5 of 17 → all outputs 0 immediately. A new start afterwards restarts cleanly from x_start. With MONO_CHECK_EN, full sweeps with step=+1 and step=−1 over x_count=4096 → mono_err stays 0.
